modexp_seq: RTL and testbench
=============================

// Module: modexp_seq
// PURPOSE
//  Initiator side of the modmult ds/ready protocol: drives an external modmult instance
//   to compute cypher = indata^exponent mod modulus by right-to-left square-and-multiply.
//  Sits between the RSA front end and modmult; both are instantiated side by side in the parent.
//  Exposes its own ds/ready handshake upstream.
// PARAMETERS
//  MPWID  32  operand/modulus/exponent width in bits (from modexp_pkg default)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  ds          in   1      start strobe; sampled only while ready=1
//  indata      in   MPWID  base; caller guarantees indata < modulus
//  exponent    in   MPWID  exponent; any value incl. 0
//  modulus     in   MPWID  modulus; caller guarantees modulus > 1
//  ready       out  1      1 = idle, cypher valid
//  cypher      out  MPWID  result, held until next completion
//  mm_ds       out  1      one-cycle start pulse to modmult
//  mm_mpand    out  MPWID  multiplicand to modmult
//  mm_mplier   out  MPWID  multiplier to modmult
//  mm_modulus  out  MPWID  latched modulus to modmult
//  mm_ready    in   1      modmult done flag
//  mm_product  in   MPWID  modmult result
//  op_count    out  16     modmult invocations of last run (MODEXP_PROFILE_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, cypher=0, mm_ds=0, mm_mpand=mm_mplier=mm_modulus=0, op_count=0.
//  Accept: ds=1 & ready=1 -> latch base<=indata, exp<=exponent, mod<=modulus, acc<=1;
//   ready=0 from next cycle. ds while ready=0 ignored (no queueing).
//  States: IDLE, CHECK, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, DONE.
//  CHECK: exp==0 -> DONE; exp[0]=1 -> MUL_ISSUE; else SQR_ISSUE.
//  MUL_ISSUE: mm_mpand=acc, mm_mplier=base, mm_ds=1 for exactly this cycle -> MUL_WAIT.
//  MUL_WAIT: mm_ready ignored in the first WAIT cycle (modmult drops ready after ds);
//   from then, first cycle with mm_ready=1: acc<=mm_product; exp>>=1;
//   new exp==0 -> DONE, else SQR_ISSUE.
//  SQR_ISSUE: mm_mpand=mm_mplier=base, mm_ds=1 -> SQR_WAIT (same ignore rule);
//   on mm_ready: base<=mm_product; if MUL not done this bit, exp>>=1; -> CHECK.
//  Squaring skipped when remaining exponent is 0 (no wasted modmult op).
//  Operands held stable from ISSUE through end of WAIT; mm_modulus = latched mod throughout.
//  DONE: cypher<=acc, ready=1 in the same cycle; -> IDLE. exp=0 gives cypher=1, 0 modmult ops.
//  Latency: 2 + sum over ops of (2 + modmult latency); upstream ds->ready is data dependent.
//  Reset mid-run: abort immediately, outputs to reset values; parent resets modmult together.
//  Widths: all datapath MPWID; no arithmetic inside block beyond shift; exp register MPWID.
// CONFIGURATION
//  MODEXP_PROFILE_EN defined: op_count port present; cleared on accept, +1 per mm_ds pulse,
//   saturates at 16'hFFFF, held after DONE.
//  Undefined: op_count port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  modexp_pkg: MPWID default, state_t enum (7 states above), typedef word_t = logic [MPWID-1:0].
//  No sub-module: modmult stays outside; parent rsa_modexp_top wires mm_* ports to it.
// TESTING  (bench pairs modexp_seq with real modmult, ready checked against model)
//  indata=4, exponent=13, modulus=497 -> cypher=445; op_count=6 (3 mul, 3 sqr).
//  indata=3, exponent=5, modulus=19 -> cypher=15; indata=2, exponent=10, modulus=1000 -> 24.
//  exponent=0, indata=7, modulus=19 -> cypher=1 within 3 cycles, no mm_ds pulse, op_count=0.
//  exponent=1, indata=5, modulus=997 -> cypher=5, exactly one mm_ds pulse.
//  ds pulsed again mid-run with new operands -> ignored, first result 445 unaffected.
//  reset asserted during MUL_WAIT -> next cycle ready=1, cypher=0, mm_ds=0; fresh run correct.

Source files
------------

// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared width, word type and sequencer state encoding for modexp_seq
package modexp_pkg;

  localparam int MPWID = 32;

  typedef logic [MPWID-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_ISSUE,
    MUL_WAIT,
    SQR_ISSUE,
    SQR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_seq_if.sv
// rtl/modexp_seq_if.sv - upstream ds/ready bus and modmult bus; op_count only with MODEXP_PROFILE_EN
interface modexp_seq_if;
  logic                 ds;
  modexp_pkg::word_t    indata;
  modexp_pkg::word_t    exponent;
  modexp_pkg::word_t    modulus;
  logic                 ready;
  modexp_pkg::word_t    cypher;
`ifdef MODEXP_PROFILE_EN
  logic [15:0]          op_count;
`endif

  modport slave (
    input  ds, indata, exponent, modulus,
    output ready, cypher
`ifdef MODEXP_PROFILE_EN
    , output op_count
`endif
  );

  modport master (
    output ds, indata, exponent, modulus,
    input  ready, cypher
`ifdef MODEXP_PROFILE_EN
    , input op_count
`endif
  );
endinterface

interface modmult_if;
  logic                 mm_ds;
  modexp_pkg::word_t    mm_mpand;
  modexp_pkg::word_t    mm_mplier;
  modexp_pkg::word_t    mm_modulus;
  logic                 mm_ready;
  modexp_pkg::word_t    mm_product;

  modport master (
    output mm_ds, mm_mpand, mm_mplier, mm_modulus,
    input  mm_ready, mm_product
  );

  modport slave (
    input  mm_ds, mm_mpand, mm_mplier, mm_modulus,
    output mm_ready, mm_product
  );
endinterface

// File: rtl/modexp_seq.sv
// rtl/modexp_seq.sv - right-to-left square-and-multiply sequencer driving an external modmult
// Optional feature: MODEXP_PROFILE_EN adds the op_count invocation counter.
module modexp_seq
  import modexp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  modexp_seq_if.slave   up,
  modmult_if.master     mm
);

  state_t state_q, state_d;
  word_t  base_q, base_d;
  word_t  exp_q, exp_d;
  word_t  mod_q, mod_d;
  word_t  acc_q, acc_d;
  word_t  cypher_q, cypher_d;
  logic   armed_q, armed_d;
  logic   mul_done_q, mul_done_d;
  logic   mm_ds;
  word_t  mpand, mplier;
  logic   op_done;

  // modmult may still show the previous ready in the first WAIT cycle
  assign op_done = armed_q && mm.mm_ready;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    cypher_d   = cypher_q;
    armed_d    = armed_q;
    mul_done_d = mul_done_q;
    mm_ds      = 1'b0;
    mpand      = '0;
    mplier     = '0;
    case (state_q)
      IDLE: begin
        if (up.ds) begin
          base_d     = up.indata;
          exp_d      = up.exponent;
          mod_d      = up.modulus;
          acc_d      = word_t'(1);
          mul_done_d = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        mul_done_d = 1'b0;
        if (exp_q == '0)     state_d = DONE;
        else if (exp_q[0])   state_d = MUL_ISSUE;
        else                 state_d = SQR_ISSUE;
      end
      MUL_ISSUE, MUL_WAIT: begin
        mpand   = acc_q;
        mplier  = base_q;
        armed_d = (state_q == MUL_WAIT);
        if (state_q == MUL_ISSUE) begin
          mm_ds   = 1'b1;
          state_d = MUL_WAIT;
        end else if (op_done) begin
          acc_d      = mm.mm_product;
          exp_d      = exp_q >> 1;
          mul_done_d = 1'b1;
          // skip the final squaring once no exponent bits remain
          state_d    = (exp_q[MPWID-1:1] == '0) ? DONE : SQR_ISSUE;
        end
      end
      SQR_ISSUE, SQR_WAIT: begin
        mpand   = base_q;
        mplier  = base_q;
        armed_d = (state_q == SQR_WAIT);
        if (state_q == SQR_ISSUE) begin
          mm_ds   = 1'b1;
          state_d = SQR_WAIT;
        end else if (op_done) begin
          base_d = mm.mm_product;
          if (!mul_done_q) exp_d = exp_q >> 1;
          state_d = CHECK;
        end
      end
      DONE: begin
        cypher_d = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      acc_q      <= '0;
      cypher_q   <= '0;
      armed_q    <= 1'b0;
      mul_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      acc_q      <= acc_d;
      cypher_q   <= cypher_d;
      armed_q    <= armed_d;
      mul_done_q <= mul_done_d;
    end
  end

`ifdef MODEXP_PROFILE_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == IDLE && up.ds)         op_count_d = '0;
    else if (mm_ds && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) op_count_q <= '0;
    else       op_count_q <= op_count_d;
  end

  assign up.op_count = op_count_q;
`endif

  assign up.ready      = (state_q == IDLE);
  assign up.cypher     = cypher_q;
  assign mm.mm_ds      = mm_ds;
  assign mm.mm_mpand   = mpand;
  assign mm.mm_mplier  = mplier;
  assign mm.mm_modulus = mod_q;

endmodule

// File: tb/tb_modexp_seq.sv
// tb/tb_modexp_seq.sv - scoreboard bench for modexp_seq paired with a behavioural modmult
module tb_modexp_seq;
  import modexp_pkg::*;

  typedef struct {
    word_t cy;
    int    ops;
    int    max_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   in_run = 1'b0;
  bit   prev_ready = 1'b1;
  int   lat = 0;
  int   pulses = 0;

  modexp_seq_if up ();
  modmult_if    mm ();

  modexp_seq dut (
    .clk   (clk),
    .reset (reset),
    .up    (up.slave),
    .mm    (mm.master)
  );

  always #5 clk = ~clk;

  // behavioural modmult: ready drops after ds, result after MM_LAT cycles
  localparam int MM_LAT = 3;
  word_t mm_res;
  int    mm_cnt;
  always @(posedge clk) begin
    if (reset) begin
      mm.mm_ready   <= 1'b1;
      mm.mm_product <= '0;
      mm_cnt        <= 0;
      mm_res        <= '0;
    end else if (mm.mm_ds && mm.mm_ready) begin
      mm_res      <= word_t'((64'(mm.mm_mpand) * 64'(mm.mm_mplier)) % 64'(mm.mm_modulus));
      mm.mm_ready <= 1'b0;
      mm_cnt      <= MM_LAT;
    end else if (!mm.mm_ready) begin
      if (mm_cnt == 1) begin
        mm.mm_ready   <= 1'b1;
        mm.mm_product <= mm_res;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: detects run start (ready 1->0) and completion (ready 0->1)
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_run     = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (prev_ready && !up.ready) begin
        in_run = 1'b1;
        lat    = 1;
        pulses = 0;
      end else if (in_run && !up.ready) begin
        lat++;
        if (lat > 5000) begin
          checks++; errors++;
          $display("FAIL run_timeout actual=%0d required<=5000", lat);
          in_run = 1'b0;
        end
      end else if (in_run && up.ready) begin
        in_run = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result actual=%0d required=none", up.cypher);
        end else begin
          e = sb.pop_front();
          chk("cypher", 64'(up.cypher), 64'(e.cy));
          chk("mm_ds_pulses", 64'(pulses), 64'(e.ops));
`ifdef MODEXP_PROFILE_EN
          chk("op_count", 64'(up.op_count), 64'(e.ops));
`endif
          if (lat > e.max_lat) begin
            errors++;
            $display("FAIL latency actual=%0d required<=%0d", lat, e.max_lat);
          end
        end
      end
      if (in_run && mm.mm_ds) pulses++;
      prev_ready = up.ready;
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!up.ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!up.ready) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic run(input word_t a, input word_t e, input word_t m,
                     input word_t cy, input int ops, input int max_lat, input bit poke);
    exp_t x;
    @(negedge clk);
    wait_ready();
    x.cy = cy; x.ops = ops; x.max_lat = max_lat;
    sb.push_back(x);
    up.ds = 1'b1; up.indata = a; up.exponent = e; up.modulus = m;
    @(negedge clk);
    up.ds = 1'b0;
    if (poke) begin
      repeat (5) @(negedge clk);
      up.ds = 1'b1; up.indata = 9; up.exponent = 7; up.modulus = 23;
      @(negedge clk);
      up.ds = 1'b0;
    end
  endtask

  initial begin
    int guard;
    up.ds = 1'b0; up.indata = '0; up.exponent = '0; up.modulus = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(up.ready), 64'd1);
    chk("rst_cypher", 64'(up.cypher), 64'd0);
    chk("rst_mm_ds", 64'(mm.mm_ds), 64'd0);
    chk("rst_mpand", 64'(mm.mm_mpand), 64'd0);
    chk("rst_mplier", 64'(mm.mm_mplier), 64'd0);
    chk("rst_modulus", 64'(mm.mm_modulus), 64'd0);
`ifdef MODEXP_PROFILE_EN
    chk("rst_op_count", 64'(up.op_count), 64'd0);
`endif

    run(4, 13, 497, 445, 6, 2000, 1'b0);
    run(3, 5, 19, 15, 4, 2000, 1'b0);
    run(2, 10, 1000, 24, 5, 2000, 1'b0);
    run(7, 0, 19, 1, 0, 3, 1'b0);
    run(5, 1, 997, 5, 1, 2000, 1'b0);
    run(4, 13, 497, 445, 6, 2000, 1'b1);

    // abort during the first MUL_WAIT
    @(negedge clk);
    wait_ready();
    up.ds = 1'b1; up.indata = 4; up.exponent = 13; up.modulus = 497;
    @(negedge clk);
    up.ds = 1'b0;
    guard = 0;
    while (!mm.mm_ds && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_saw_mm_ds", 64'(mm.mm_ds), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(up.ready), 64'd1);
    chk("abort_cypher", 64'(up.cypher), 64'd0);
    chk("abort_mm_ds", 64'(mm.mm_ds), 64'd0);
    chk("abort_modulus", 64'(mm.mm_modulus), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run(4, 13, 497, 445, 6, 2000, 1'b0);

    guard = 0;
    while ((sb.size() != 0 || in_run) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
